// File: rtl/paced_output_queues.sv
// Output-queue stage: an input FSM steers AXI-Stream packets (unicast or multicast)
// into per-queue FWFT FIFOs; optional inter-packet pacing is enabled by OQ_PACING_EN.

module paced_oq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    // A paired read and write is always accepted, so occupancy stays put even when full or empty.
    assign wr_ok_s = wr_en & (~full | rd_en);
    assign rd_ok_s = rd_en & (~empty | wr_en);

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (rd_ok_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            if (wr_ok_s && !rd_ok_s)      count_r <= count_r + CNT_ONE;
            else if (rd_ok_s && !wr_ok_s) count_r <= count_r - CNT_ONE;
        end
    end

    // Storage array; contents are only observed while occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (wr_ok_s) mem_r[wr_ptr_r] <= wr_data;
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign empty   = (count_r == '0);
    assign full    = (count_r == (AW+1)'(DEPTH));
    assign count   = count_r;
endmodule

module paced_output_queues #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_QUEUES         = 5,
    parameter int BUFFER_WORDS       = 128,
    parameter int META_DEPTH         = 4
) (
    input  logic                                           axi_aclk,
    input  logic                                           axi_resetn,
    input  logic                                           utimer_clk,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                  ipd_value,
    input  logic [C_AXIS_DATA_WIDTH-1:0]                   s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]                 s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]                  s_axis_tuser,
    input  logic                                           s_axis_tvalid,
    input  logic                                           s_axis_tlast,
    output logic                                           s_axis_tready,
    output logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0]      m_axis_tstrb,
    output logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]       m_axis_tuser,
    output logic [NUM_QUEUES-1:0]                          m_axis_tlast,
    output logic [NUM_QUEUES-1:0]                          m_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]                          m_axis_tready,
    output logic [NUM_QUEUES-1:0]                          pkt_stored,
    output logic [NUM_QUEUES-1:0]                          pkt_dropped,
    output logic [NUM_QUEUES-1:0]                          pkt_removed,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                  bytes_stored,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                  bytes_dropped,
    output logic [NUM_QUEUES*C_S_AXI_DATA_WIDTH-1:0]       bytes_removed
);
    localparam int DW        = C_AXIS_DATA_WIDTH;
    localparam int SW        = C_AXIS_DATA_WIDTH / 8;
    localparam int UW        = C_AXIS_TUSER_WIDTH;
    localparam int SAW       = C_S_AXI_DATA_WIDTH;
    localparam int DFW       = DW + SW + 1;
    localparam int CW_D      = $clog2(BUFFER_WORDS) + 1;
    localparam int CW_M      = $clog2(META_DEPTH) + 1;
    localparam int THRESH    = (1600 + SW - 1) / SW;
    localparam int NF_LIMIT  = (BUFFER_WORDS > THRESH) ? (BUFFER_WORDS - THRESH) : 0;
    localparam logic NF_ALWAYS = (BUFFER_WORDS < THRESH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_PKT = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [NUM_QUEUES-1:0]  oq_s;
    logic [15:0]            len_s;
    logic [NUM_QUEUES-1:0]  oq_r;
    logic                   first_r;
    logic                   tready_r;
    logic                   accept_s;
    logic                   store_s;
    logic                   drop_s;
    logic                   wr_beat_s;
    logic [NUM_QUEUES-1:0]  nearly_full_s;
    logic [NUM_QUEUES-1:0]  pkt_stored_r;
    logic [NUM_QUEUES-1:0]  pkt_dropped_r;
    logic [SAW-1:0]         bytes_stored_r;
    logic [SAW-1:0]         bytes_dropped_r;

    assign oq_s     = s_axis_tuser[24 +: NUM_QUEUES];
    assign len_s    = s_axis_tuser[15:0];
    assign accept_s = s_axis_tvalid & tready_r;

    // Input FSM state register.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) state_r <= ST_IDLE;
        else             state_r <= state_s;
    end

    // Input FSM next state: admit only if every destination has room for a full packet.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    if ((oq_s != '0) && ((oq_s & nearly_full_s) == '0)) state_s = ST_WR_PKT;
                    else                                                state_s = ST_DROP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_PKT, ST_DROP: begin
                if (accept_s && s_axis_tlast) state_s = ST_IDLE;
                else                          state_s = state_r;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Input FSM decoded actions.
    always_comb begin
        store_s   = 1'b0;
        drop_s    = 1'b0;
        wr_beat_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                store_s = s_axis_tvalid & (state_s == ST_WR_PKT);
                drop_s  = s_axis_tvalid & (state_s == ST_DROP);
            end
            ST_WR_PKT: wr_beat_s = accept_s;
            ST_DROP:   wr_beat_s = 1'b0;
            default:   wr_beat_s = 1'b0;
        endcase
    end

    // Registered handshake, destination latch, header flag and input statistics.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            tready_r        <= 1'b0;
            oq_r            <= '0;
            first_r         <= 1'b0;
            pkt_stored_r    <= '0;
            pkt_dropped_r   <= '0;
            bytes_stored_r  <= '0;
            bytes_dropped_r <= '0;
        end else begin
            tready_r <= (state_s != ST_IDLE);
            if (state_r == ST_IDLE && s_axis_tvalid) oq_r <= oq_s;
            if (store_s)        first_r <= 1'b1;
            else if (wr_beat_s) first_r <= 1'b0;
            pkt_stored_r    <= store_s ? oq_s : '0;
            pkt_dropped_r   <= drop_s  ? oq_s : '0;
            bytes_stored_r  <= store_s ? SAW'(len_s) : '0;
            bytes_dropped_r <= drop_s  ? SAW'(len_s) : '0;
        end
    end

    assign s_axis_tready = tready_r;
    assign pkt_stored    = pkt_stored_r;
    assign pkt_dropped   = pkt_dropped_r;
    assign bytes_stored  = bytes_stored_r;
    assign bytes_dropped = bytes_dropped_r;

`ifndef OQ_PACING_EN
    logic unused_pacing_s;
    assign unused_pacing_s = ^{utimer_clk, ipd_value};
`endif

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
        logic            data_wr_s;
        logic            meta_wr_s;
        logic            rd_s;
        logic            valid_s;
        logic            d_empty_s;
        logic            d_last_s;
        logic            m_full_s;
        logic            data_full_unused_s;
        logic            meta_empty_unused_s;
        logic [CW_M-1:0] meta_cnt_unused_s;
        logic [CW_D-1:0] d_cnt_s;
        logic [DFW-1:0]  d_out_s;
        logic [UW-1:0]   m_out_s;
        logic            body_r;
        logic            nf_r;
        logic            pkt_rem_r;
        logic [SAW-1:0]  bytes_rem_r;

        assign data_wr_s = wr_beat_s & oq_r[q];
        assign meta_wr_s = data_wr_s & first_r;
        assign d_last_s  = d_out_s[DFW-1];
        assign rd_s      = valid_s & m_axis_tready[q];

        paced_oq_fifo #(.WIDTH(DFW), .DEPTH(BUFFER_WORDS)) u_data (
            .clk     (axi_aclk),
            .rst_n   (axi_resetn),
            .wr_en   (data_wr_s),
            .wr_data ({s_axis_tlast, s_axis_tstrb, s_axis_tdata}),
            .rd_en   (rd_s),
            .rd_data (d_out_s),
            .empty   (d_empty_s),
            .full    (data_full_unused_s),
            .count   (d_cnt_s)
        );

        paced_oq_fifo #(.WIDTH(UW), .DEPTH(META_DEPTH)) u_meta (
            .clk     (axi_aclk),
            .rst_n   (axi_resetn),
            .wr_en   (meta_wr_s),
            .wr_data (s_axis_tuser),
            .rd_en   (rd_s & ~body_r),
            .rd_data (m_out_s),
            .empty   (meta_empty_unused_s),
            .full    (m_full_s),
            .count   (meta_cnt_unused_s)
        );

        // Header/body tracking, admission flag and removal statistics.
        always_ff @(posedge axi_aclk or negedge axi_resetn) begin
            if (!axi_resetn) begin
                body_r      <= 1'b0;
                nf_r        <= 1'b0;
                pkt_rem_r   <= 1'b0;
                bytes_rem_r <= '0;
            end else begin
                if (rd_s) body_r <= ~d_last_s;
                nf_r        <= NF_ALWAYS | (d_cnt_s > CW_D'(NF_LIMIT)) | m_full_s;
                pkt_rem_r   <= rd_s & ~body_r;
                bytes_rem_r <= (rd_s & ~body_r) ? SAW'(m_out_s[15:0]) : '0;
            end
        end

`ifdef OQ_PACING_EN
        logic [SAW-1:0] gap_r;

        // Inter-packet gap: reload on the last beat read, count down on ticks.
        always_ff @(posedge axi_aclk or negedge axi_resetn) begin
            if (!axi_resetn)                   gap_r <= '0;
            else if (rd_s && d_last_s)         gap_r <= ipd_value;
            else if (utimer_clk && gap_r != '0) gap_r <= gap_r - SAW'(1);
        end

        assign valid_s = ~d_empty_s & (body_r | (gap_r == '0));
`else
        assign valid_s = ~d_empty_s;
`endif

        assign nearly_full_s[q]              = nf_r;
        assign m_axis_tdata[q*DW +: DW]      = d_out_s[DW-1:0];
        assign m_axis_tstrb[q*SW +: SW]      = d_out_s[DW +: SW];
        assign m_axis_tuser[q*UW +: UW]      = m_out_s;
        assign m_axis_tlast[q]               = d_last_s;
        assign m_axis_tvalid[q]              = valid_s;
        assign pkt_removed[q]                = pkt_rem_r;
        assign bytes_removed[q*SAW +: SAW]   = bytes_rem_r;
    end
endmodule
